// File: rtl/mod_down_timer_pkg.sv
// mod_down_timer_pkg: state type, counter width helper and load clamp shared by mod_down_timer
package mod_down_timer_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  function automatic int width_of(input int final_value);
    return (final_value < 2) ? 1 : $clog2(final_value + 1);
  endfunction
  function automatic int clamp(input int value, input int final_value);
    return (value > final_value) ? final_value : value;
  endfunction
endpackage

// File: rtl/mod_down_timer.sv
// mod_down_timer: loadable cascadable modulus down-counter; define MOD_DOWN_TIMER_AUTORELOAD_EN to honor auto_reload
module mod_down_timer
  import mod_down_timer_pkg::*;
#(
  parameter int FINAL_VALUE = 9,
  localparam int SIZE = width_of(FINAL_VALUE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] load_value,
  input  logic            enable,
  input  logic            stop,
  input  logic            auto_reload,
  output logic [SIZE-1:0] count,
  output logic            busy,
  output logic            done
);
  state_e state_q, state_d;
  logic [SIZE-1:0] count_q, count_d, reload_q, reload_d, ld;
  logic busy_q, busy_d, done_q, done_d, ar, halt, step, at_one, at_zero;
`ifdef MOD_DOWN_TIMER_AUTORELOAD_EN
  assign ar = auto_reload;
`else
  assign ar = auto_reload & 1'b0;
`endif
  assign ld = SIZE'(clamp(int'(load_value), FINAL_VALUE));
  assign halt = stop && state_q == RUN;
  assign step = state_q == RUN && enable;
  assign at_one = count_q == SIZE'(1);
  assign at_zero = count_q == '0;
  // state and registered outputs, synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  // next state: stop aborts a run, start (re)loads, the last enabled step leaves RUN unless reloading
  always_comb begin
    state_d = halt ? IDLE :
              start ? ((ld == '0 && !ar) ? IDLE : RUN) :
              (step && (at_one || at_zero) && !ar) ? IDLE : state_q;
  end
  // datapath and output flags; done marks every transition into a zero count
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (halt) begin
      done_d = 1'b0;
    end else if (start) begin
      count_d  = ld;
      reload_d = ld;
      done_d   = ld == '0;
    end else if (step && !at_zero) begin
      count_d = count_q - SIZE'(1);
      done_d  = at_one;
`ifdef MOD_DOWN_TIMER_AUTORELOAD_EN
    end else if (step && ar) begin
      count_d = reload_q;
      done_d  = reload_q == '0;
`endif
    end
    busy_d = state_d == RUN;
  end
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: tb/tb_mod_down_timer.sv
// tb_mod_down_timer: directed self-checking bench for mod_down_timer
module tb_mod_down_timer;
  logic clk = 1'b0, reset, start, enable, stop, auto_reload;
  logic [3:0] load_value, count;
  logic busy, done;
  int total = 0, bad = 0;

  mod_down_timer dut (
    .clk(clk), .reset(reset), .start(start), .load_value(load_value),
    .enable(enable), .stop(stop), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; load_value = 4'd5; enable = 1'b1; stop = 1'b0; auto_reload = 1'b0;
    step();
    step();
    reset = 1'b0; start = 1'b0; enable = 1'b0;
    total++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
    step();
    total++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_idle: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
  endtask

  task automatic test_countdown();
    start = 1'b1; load_value = 4'd9; enable = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, done} !== {4'd9, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL countdown_load: got count=%0d busy=%b done=%b, want 9 1 0", count, busy, done);
    end
    for (int i = 8; i >= 0; i--) begin
      step();
      total++;
      if ({count, busy, done} !== {4'(i), i != 0, i == 0}) begin
        bad++;
        $display("FAIL countdown_%0d: got count=%0d busy=%b done=%b, want %0d %b %b",
                 i, count, busy, done, i, i != 0, i == 0);
      end
    end
    step();
    total++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL countdown_hold: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
  endtask

  task automatic test_clamp();
    start = 1'b1; load_value = 4'd15; enable = 1'b0;
    step();
    total++;
    if ({count, busy, done} !== {4'd9, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL clamp_15: got count=%0d busy=%b done=%b, want 9 1 0", count, busy, done);
    end
    load_value = 4'd0;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL load_zero: got count=%0d busy=%b done=%b, want 0 0 1", count, busy, done);
    end
    step();
    total++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL load_zero_after: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] seq [12];
    seq = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
    auto_reload = 1'b1; start = 1'b1; load_value = 4'd3; enable = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, done} !== {4'd3, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL ar_load: got count=%0d busy=%b done=%b, want 3 1 0", count, busy, done);
    end
`ifdef MOD_DOWN_TIMER_AUTORELOAD_EN
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if ({count, busy, done} !== {seq[i], 1'b1, seq[i] == 4'd0}) begin
        bad++;
        $display("FAIL ar_cycle_%0d: got count=%0d busy=%b done=%b, want %0d 1 %b",
                 i, count, busy, done, seq[i], seq[i] == 4'd0);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if ({count, busy, done} !== {4'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL ar_stop: got count=%0d busy=%b done=%b, want 3 0 0", count, busy, done);
    end
`else
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({count, busy, done} !== {seq[i], seq[i] != 4'd0, seq[i] == 4'd0}) begin
        bad++;
        $display("FAIL ar_ignored_%0d: got count=%0d busy=%b done=%b, want %0d %b %b",
                 i, count, busy, done, seq[i], seq[i] != 4'd0, seq[i] == 4'd0);
      end
    end
    step();
    total++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL ar_ignored_hold: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
`endif
    auto_reload = 1'b0; enable = 1'b0;
  endtask

  task automatic test_enable_toggle();
    start = 1'b1; load_value = 4'd5; enable = 1'b0;
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      enable = (c % 2) == 0;
      step();
      total++;
      if ({count, busy, done} !== {4'(5 - c / 2), c != 10, c == 10}) begin
        bad++;
        $display("FAIL toggle_%0d: got count=%0d busy=%b done=%b, want %0d %b %b",
                 c, count, busy, done, 5 - c / 2, c != 10, c == 10);
      end
    end
  endtask

  task automatic test_interrupt();
    start = 1'b1; load_value = 4'd7; enable = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    total++;
    if ({count, busy, done} !== {4'd4, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL int_run: got count=%0d busy=%b done=%b, want 4 1 0", count, busy, done);
    end
    start = 1'b1; load_value = 4'd4;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, done} !== {4'd4, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL int_restart: got count=%0d busy=%b done=%b, want 4 1 0", count, busy, done);
    end
    step();
    total++;
    if (count !== 4'd3) begin
      bad++;
      $display("FAIL int_continue: got count=%0d, want 3", count);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if ({count, busy, done} !== {4'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL int_stop: got count=%0d busy=%b done=%b, want 3 0 0", count, busy, done);
    end
    step();
    total++;
    if ({count, busy, done} !== {4'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL int_idle_enable: got count=%0d busy=%b done=%b, want 3 0 0", count, busy, done);
    end
    start = 1'b1; load_value = 4'd6;
    step();
    total++;
    if ({count, busy} !== {4'd6, 1'b1}) begin
      bad++;
      $display("FAIL int_reload: got count=%0d busy=%b, want 6 1", count, busy);
    end
    reset = 1'b1; load_value = 4'd5;
    step();
    reset = 1'b0; start = 1'b0;
    total++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL int_reset_wins: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
    step();
    total++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL int_after_reset: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; load_value = 4'd1; enable = 1'b1;
    step();
    load_value = 4'd2;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, done} !== {4'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL b2b_restart: got count=%0d busy=%b done=%b, want 2 1 0", count, busy, done);
    end
    step();
    step();
    total++;
    if ({count, busy, done} !== {4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_done: got count=%0d busy=%b done=%b, want 0 0 1", count, busy, done);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_clamp();
    test_auto_reload();
    test_enable_toggle();
    test_interrupt();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_down_timer.md
# mod_down_timer

Loadable, cascadable modulus down-counter for the counter library: the counting-down counterpart to the up-counting modulus counter. It loads a start value, decrements on each enabled clock down to zero, and flags terminal count. Optional auto-reload makes it a free-running divide-by-(N+1) tick source for BCD chains and timeouts.

## Interface
- FINAL_VALUE, 9, largest loadable value; default gives a BCD digit (9..0)
- SIZE, $clog2(FINAL_VALUE+1) (minimum 1), derived localparam; never overridden
- clk  input  1  rising-edge clock, single domain
- reset  input  1  synchronous, active-high reset
- start  input  1  load request, sampled each clock edge
- load_value  input  SIZE  value loaded on start
- enable  input  1  count enable (cascade input from a lower digit's done)
- stop  input  1  abort the current run
- auto_reload  input  1  reload at zero instead of stopping (see Configuration)
- count  output  SIZE  current value
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high in the first cycle count shows 0

## Operation
- Two-state FSM: IDLE, RUN; reload_reg holds the last loaded value.
- Load value is clamp(load_value) = min(load_value, FINAL_VALUE); the clamp is saturating, never a wrap.
- Priority per edge: reset > stop > start > enable.
- reset: state IDLE, count 0, reload_reg 0, busy 0, done 0.
- stop: state IDLE; count holds; done 0. Stop has no effect in IDLE.
- start, from either state: count and reload_reg take the clamped load_value; state RUN.
  - A start in RUN restarts the run and discards the pending decrement.
  - If the clamped value is 0: done is asserted next cycle. State is IDLE, or RUN if auto-reload is active.
- RUN, enable=1, count>1: count decrements by 1.
- RUN, enable=1, count==1: count becomes 0; done is asserted next cycle.
  - Auto-reload inactive: state IDLE.
  - Auto-reload active: state stays RUN.
- RUN, enable=1, count==0 (auto-reload only): count takes reload_reg; done is asserted again only if reload_reg==0.
- RUN, enable=0: hold.
- IDLE: enable is ignored; count holds.
- done is a registered flag: set exactly when the next count is 0 due to load, decrement or reload, and cleared otherwise. It is never high for two consecutive cycles unless reload_reg==0 with enable held high.
- busy = (state==RUN), registered.

## Timing
- All outputs are registered; zero combinational input-to-output paths.
- start at edge k: count=clamp(load_value) and busy=1 are visible after edge k.
- Load N≥1 with enable held high: count reaches 0 and done=1 after edge k+N. busy falls at the same edge when not auto-reloading.
- Auto-reload period: N+1 enabled cycles. The sequence is N, N-1, …, 0, N, …, with done high once per period.
- Reset mid-run takes effect at the next edge regardless of the other inputs.

## Configuration
- MOD_DOWN_TIMER_AUTORELOAD_EN defined: the auto_reload port is honored as described above.
- Undefined: the auto_reload port remains but is ignored (treated as 0). The count==0 reload branch is not compiled, and every run ends in IDLE at zero.

## Structure
- Package mod_down_timer_pkg holds:
  - the state typedef (IDLE, RUN), one bit;
  - a clamp function;
  - the width helper that computes SIZE with its minimum-1 rule.
- There is no natural sub-module: one FSM plus a SIZE-bit datapath in a single file.

## Test plan
- reset=1 for 2 cycles, then release -> count=0, busy=0, done=0.
- start with load_value=9, enable=1 -> count 9,8,…,0. done is high only in the cycle count=0 (10th cycle after start). busy falls with it, and count holds 0 afterwards.
- load_value=15 with FINAL_VALUE=9 -> count loads 9 (clamped); load_value=0 -> done pulses next cycle and busy stays 0.
- Macro defined, auto_reload=1, load 3, enable=1 for 12 cycles -> sequence 3,2,1,0,3,2,1,0,3,…, with done once per 4 cycles.
- Load 5, toggle enable every other cycle -> count decrements only on enabled edges, reaching 0 after 10 cycles.
- Interrupt checks:
  - Load 7 and wait 3 cycles, then start with 4 -> count jumps to 4 and continues.
  - Then assert stop -> IDLE with count held.
  - Then assert reset with start=1 simultaneously -> count=0 and IDLE (reset wins).
